// File: rtl/alu_pkg.sv
// Shared types and constants for the round-robin ALU arbiter.
// States follow the issue/wait/respond handshake with one shared ALU.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int NUM_REQ   = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_OPW   = 2;

endpackage

// File: rtl/decoder_2_4.sv
// 2-to-4 one-hot decoder, MSB-first: sel 0 -> 4'b1000, sel 3 -> 4'b0001.
// Purely combinational; output is all-zero while disabled.
module decoder_2_4 (
    input  logic       i_en,
    input  logic [1:0] i_sel,
    output logic [3:0] o_y
);

    always_comb begin
        o_y = 4'b0000;
        if (i_en) begin
            o_y = 4'b1000 >> i_sel;
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU among four requesters.
// Latency: grant+start 1 cycle after req, ack 1 cycle after done; requesters hold req until ack.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*OPW-1:0]     op_in,
    input  logic [NUM_REQ*WIDTH-1:0]   a_in,
    input  logic [NUM_REQ*WIDTH-1:0]   b_in,
    output logic                       alu_start,
    output logic [OPW-1:0]             alu_op,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    input  logic                       alu_done,
    input  logic [WIDTH-1:0]           alu_result,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         ack,
    output logic [WIDTH-1:0]           result,
    output logic                       busy
);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_ptr;
    logic [1:0]       r_idx;
    logic [1:0]       w_pick;
    logic [1:0]       w_cand;
    logic             w_found;
    logic             w_any;
    logic             w_active;
    logic             w_resp;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;

    // Requester n owns req bit 3-n, which for a 2-bit index is simply ~n.
    always_comb begin
        w_any   = |req;
        w_pick  = r_ptr;
        w_cand  = r_ptr;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && req[~w_cand]) begin
                w_pick  = w_cand;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (alu_done) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= 2'd0;
            r_idx    <= 2'd0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_idx <= w_pick;
                r_op  <= op_in[w_pick*OPW +: OPW];
                r_a   <= a_in[w_pick*WIDTH +: WIDTH];
                r_b   <= b_in[w_pick*WIDTH +: WIDTH];
            end
            if (r_state == WAIT && alu_done) begin
                r_result <= alu_result;
            end
            if (r_state == RESP) begin
                r_ptr <= r_idx + 2'd1;
            end
        end
    end

    assign w_active  = (r_state != IDLE);
    assign w_resp    = (r_state == RESP);
    assign alu_start = (r_state == ISSUE);
    assign busy      = w_active;
    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign result    = r_result;

    decoder_2_4 u_gnt_dec (
        .i_en  (w_active),
        .i_sel (r_idx),
        .o_y   (gnt)
    );

    decoder_2_4 u_ack_dec (
        .i_en  (w_resp),
        .i_sel (r_idx),
        .o_y   (ack)
    );

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench: transaction-level ownership model plus directed and random scenarios.
module tb_alu_rr_arbiter;

    localparam int W   = 8;
    localparam int OPW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req;
    logic [4*OPW-1:0] op_in;
    logic [4*W-1:0] a_in;
    logic [4*W-1:0] b_in;
    logic           alu_start;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           alu_done;
    logic [W-1:0]   alu_result;
    logic [3:0]     gnt;
    logic [3:0]     ack;
    logic [W-1:0]   result;
    logic           busy;

    alu_rr_arbiter #(.WIDTH(W), .OPW(OPW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .op_in      (op_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .gnt        (gnt),
        .ack        (ack),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: who owns the ALU, cycles since grant, whether the answer is back.
    int             m_owner;
    int             m_age;
    bit             m_done;
    int             m_ptr;
    logic [OPW-1:0] m_op;
    logic [W-1:0]   m_a;
    logic [W-1:0]   m_b;
    logic [W-1:0]   m_res;

    int alu_lat = 1;
    int alu_cnt = 0;
    int pend[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] alu_f(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic int pick();
        for (int k = 0; k < 4; k++) begin
            int n;
            n = (m_ptr + k) % 4;
            if (req[3-n]) return n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_done  = 0;
        m_ptr   = 0;
        m_op    = '0;
        m_a     = '0;
        m_b     = '0;
        m_res   = '0;
    endtask

    task automatic model_edge();
        int n;
        if (rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            n = pick();
            if (n >= 0) begin
                m_owner = n;
                m_age   = 0;
                m_op    = op_in[n*OPW +: OPW];
                m_a     = a_in[n*W +: W];
                m_b     = b_in[n*W +: W];
            end
        end else if (m_done) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_done  = 0;
        end else begin
            if (m_age >= 1 && alu_done) begin
                m_done = 1;
                m_res  = alu_result;
            end
            m_age++;
        end
    endtask

    task automatic compare();
        logic [3:0] e_gnt;
        logic [3:0] e_ack;
        logic [3:0] one;
        one   = 4'b1000;
        e_gnt = (m_owner >= 0) ? (one >> m_owner) : 4'b0000;
        e_ack = m_done ? e_gnt : 4'b0000;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("ack", 32'(ack), 32'(e_ack));
        chk("alu_start", 32'(alu_start), 32'(m_owner >= 0 && m_age == 0));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("result", 32'(result), 32'(m_res));
        if (m_owner >= 0) begin
            chk("alu_op", 32'(alu_op), 32'(m_op));
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
        end
    endtask

    // ALU stand-in: done pulses alu_lat cycles after the start cycle.
    task automatic alu_env();
        alu_done = 1'b0;
        alu_result = W'($urandom);
        if (alu_start) begin
            alu_cnt = alu_lat;
        end else if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                alu_done   = 1'b1;
                alu_result = alu_f(alu_op, alu_a, alu_b);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        alu_env();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        alu_cnt  = 0;
        alu_done = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_ack(input string name, input int max);
        int t;
        t = 0;
        while (!m_done && t < max) begin
            tick();
            t++;
        end
        if (!m_done) begin
            errors++;
            $display("FAIL %s: no ack within %0d cycles", name, max);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq[$];
        logic [3:0] exp_seq[5];
        int n_ack;
        int ack_len;

        rst = 1'b1; req = '0; op_in = '0; a_in = '0; b_in = '0;
        alu_done = 1'b0; alu_result = '0;
        model_reset();
        repeat (2) tick();
        chk("rst_gnt", 32'(gnt), 'h0);
        chk("rst_busy", 32'(busy), 'h0);
        chk("rst_start", 32'(alu_start), 'h0);
        chk("rst_ack", 32'(ack), 'h0);
        chk("rst_alu_op", 32'(alu_op), 'h0);
        chk("rst_alu_a", 32'(alu_a), 'h0);
        chk("rst_alu_b", 32'(alu_b), 'h0);
        chk("rst_result", 32'(result), 'h0);
        rst = 1'b0;
        tick();

        // Single request from requester 2, ALU answers one cycle after start.
        req = 4'b0010; op_in[5:4] = 2'b01; a_in[23:16] = 8'h12; b_in[23:16] = 8'h05;
        alu_lat = 1;
        tick();
        chk("s1_start_c1", 32'(alu_start), 'h1);
        chk("s1_gnt_c1", 32'(gnt), 'h2);
        tick();
        chk("s1_gnt_c2", 32'(gnt), 'h2);
        chk("s1_start_c2", 32'(alu_start), 'h0);
        tick();
        chk("s1_ack_c3", 32'(ack), 'h2);
        chk("s1_result_c3", 32'(result), 'h0D);
        chk("s1_gnt_c3", 32'(gnt), 'h2);
        req = 4'b0000;
        tick();
        chk("s1_busy_c4", 32'(busy), 'h0);

        // All four requesting continuously from reset.
        do_reset();
        req = 4'b1111;
        op_in = OPW*4'($urandom); a_in = $urandom; b_in = $urandom;
        n_ack = 0;
        for (int t = 0; t < 40 && seq.size() < 5; t++) begin
            tick();
            if (alu_start) seq.push_back(gnt);
            if (ack != 4'b0000) n_ack++;
        end
        exp_seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        if (seq.size() < 5) begin
            errors++;
            $display("FAIL s2_grants: only %0d grants, required 5", seq.size());
        end else begin
            for (int i = 0; i < 5; i++) chk("s2_grant_order", 32'(seq[i]), 32'(exp_seq[i]));
        end
        chk("s2_acks", 32'(n_ack), 'h4);
        req = 4'b0000;
        repeat (6) tick();

        // Fairness after wrap: serve 3, then 0 and 3 together.
        do_reset();
        req = 4'b0001;
        tick();
        wait_ack("s3_first", 10);
        req = 4'b1001;
        tick();
        tick();
        chk("s3_gnt_req0", 32'(gnt), 'h8);
        wait_ack("s3_second", 10);
        req = 4'b0000;
        repeat (2) tick();

        // Long ALU latency; operand changes in WAIT must not leak through.
        alu_lat = 5;
        req = 4'b0100; op_in[3:2] = 2'd2; a_in[15:8] = 8'hA5; b_in[15:8] = 8'h3C;
        tick();
        tick();
        a_in[15:8] = 8'h00;
        tick();
        chk("s4_alu_a_held", 32'(alu_a), 'hA5);
        chk("s4_gnt_held", 32'(gnt), 'h4);
        chk("s4_no_ack", 32'(ack), 'h0);
        wait_ack("s4", 12);
        req = 4'b0000;
        ack_len = 0;
        if (ack != 4'b0000) ack_len++;
        tick();
        if (ack != 4'b0000) ack_len++;
        chk("s4_ack_len", 32'(ack_len), 'h1);
        chk("s4_result", 32'(result), 'h24);
        tick();

        // Reset in the middle of WAIT, with the ALU answer arriving afterwards.
        req = 4'b0010; a_in[23:16] = 8'h40; b_in[23:16] = 8'h01; op_in[5:4] = 2'd0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        req = 4'b0000;
        #1;
        chk("s5_gnt_rst", 32'(gnt), 'h0);
        chk("s5_busy_rst", 32'(busy), 'h0);
        chk("s5_start_rst", 32'(alu_start), 'h0);
        chk("s5_ack_rst", 32'(ack), 'h0);
        model_reset();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        alu_lat = 1;
        req = 4'b1010;
        tick();
        chk("s5_gnt_ptr0", 32'(gnt), 'h8);
        wait_ack("s5", 10);
        req = 4'b0000;
        tick();

        // Requester 1 withdraws its request mid-transaction.
        alu_lat = 3;
        req = 4'b0100;
        tick();
        tick();
        req = 4'b0000;
        wait_ack("s6", 10);
        chk("s6_ack", 32'(ack), 'h4);
        repeat (3) tick();
        chk("s6_idle_busy", 32'(busy), 'h0);
        chk("s6_idle_gnt", 32'(gnt), 'h0);

        // Randomised traffic with varying ALU latency.
        for (int n = 0; n < 4; n++) pend[n] = 0;
        for (int t = 0; t < 1500; t++) begin
            alu_lat = $urandom_range(1, 6);
            for (int n = 0; n < 4; n++) begin
                if (m_done && m_owner == n) begin
                    pend[n] = 0;
                    req[3-n] = 1'b0;
                end else if (pend[n] == 0 && $urandom_range(0, 3) == 0) begin
                    pend[n] = 1;
                    req[3-n] = 1'b1;
                    op_in[n*OPW +: OPW] = OPW'($urandom);
                    a_in[n*W +: W] = W'($urandom);
                    b_in[n*W +: W] = W'($urandom);
                end else if (pend[n] == 1 && $urandom_range(0, 49) == 0) begin
                    pend[n] = 0;
                    req[3-n] = 1'b0;
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one multi-cycle ALU among four requesters using round-robin arbitration.
- Latches the winning requester's opcode and operands, issues a one-cycle start to the ALU, and waits for done.
- Returns the result with a one-cycle ack to the winner.
- Sits between requester ports and the ALU; grant vectors use the decoder_2_4 one-hot order.

Parameters:
- WIDTH, 8, operand/result width in bits.
- OPW, 2, opcode width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  request per requester; bit (3-n) belongs to requester n.
- op_in  in  4*OPW  opcodes; slice n is [n*OPW +: OPW].
- a_in  in  4*WIDTH  operand A; slice n is [n*WIDTH +: WIDTH].
- b_in  in  4*WIDTH  operand B; same slicing as a_in.
- alu_start  out  1  one-cycle pulse that launches an ALU operation.
- alu_op  out  OPW  latched opcode, held stable from ISSUE through WAIT.
- alu_a  out  WIDTH  latched operand A, held stable from ISSUE through WAIT.
- alu_b  out  WIDTH  latched operand B, held stable from ISSUE through WAIT.
- alu_done  in  1  ALU completion strobe.
- alu_result  in  WIDTH  ALU result, valid when alu_done=1.
- gnt  out  4  one-hot grant, bit (3-n) for requester n.
- ack  out  4  one-cycle completion pulse, bit (3-n) for requester n.
- result  out  WIDTH  registered result.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE, ptr=0 (requester 0 has highest priority).
  - alu_start=0, gnt=0, ack=0, busy=0.
  - alu_op=0, alu_a=0, alu_b=0, result=0, idx=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, pick the first requesting index in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Latch idx, op, a and b from that slice; go to ISSUE.
  - With no requests, stay in IDLE with all outputs 0.
- ISSUE:
  - alu_start=1 for exactly this cycle.
  - gnt = decoder order of idx (idx 0 -> 4'b1000, idx 3 -> 4'b0001).
  - Go to WAIT unconditionally.
  - alu_done is ignored in this cycle; the ALU's minimum latency is 1 cycle after start.
- WAIT:
  - gnt held.
  - On alu_done=1, register alu_result into result and go to RESP.
  - Otherwise stay in WAIT. There is no timeout.
- RESP:
  - ack bit for idx =1 for one cycle; gnt held; result valid.
  - Set ptr=idx+1 (2-bit wrap, 3 -> 0); go to IDLE.
- busy=1 in ISSUE, WAIT and RESP.
- Minimum latency: req sampled at edge 0, alu_start during cycle 1, done sampled during cycle 2, ack during cycle 3.
- Requester contract: hold req and operands until ack. Operands are latched in IDLE, so later changes have no effect.
- req dropped mid-transaction: the transaction still completes and ack still pulses.
- Back-to-back: after RESP there is always one IDLE cycle before the next ISSUE, so the max throughput is 1 op per 4 cycles.
- req changes in RESP have no effect; arbitration happens only in IDLE.
- Simultaneous requests resolve purely by ptr order; no requester waits more than 3 grants.
- rst asserted mid-operation aborts immediately with reset values. A pending ALU done after reset release is ignored because the FSM is in IDLE.
- result holds its value until the next capture.

Decomposition:
- Shared package alu_pkg holds:
  - state enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - NUM_REQ=4;
  - default WIDTH and OPW constants.
- The existing decoder_2_4 is instantiated twice, each gated by state:
  - once to produce gnt from idx;
  - once to produce ack from idx.
- Round-robin select logic stays inline; no new sub-module.

Test Plan:
- Single request: requester 2, op=2'b01, a=8'h12, b=8'h05, ALU done 1 cycle after start with 8'h0D.
  - alu_start in cycle 1, gnt=4'b0010 in cycles 1-3.
  - ack=4'b0010 in cycle 3, result=8'h0D, busy falls in cycle 4.
- All four requesting continuously from reset: grant order 0, 1, 2, 3, 0.
  - gnt sequence 1000, 0100, 0010, 0001, 1000; one ack per grant.
- Fairness after wrap: serve requester 3, then req from 0 and 3 together.
  - Requester 0 is granted first (ptr=0).
- Variable ALU latency: done 5 cycles after start.
  - FSM stays in WAIT, gnt and alu_a/b stable, ack exactly 1 cycle long.
  - Operand change on a_in during WAIT has no effect on alu_a.
- Reset mid-WAIT: assert rst during WAIT.
  - gnt, busy, alu_start and ack go 0 immediately.
  - A late alu_done after release produces no ack; the next request is served normally from ptr=0.
- Request withdrawn: requester 1 drops req in WAIT.
  - ack=4'b0100 still pulses; the next IDLE grants no one if req=0.
